// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-ported memory between instruction fetch (I)
// and the data stage (D). D has priority; a starvation counter guarantees I progress.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IReq,
    input  logic [WORD_SIZE-1:0] IAddr,
    output logic [WORD_SIZE-1:0] IRData,
    output logic                 IValid,
    output logic                 IBusy,
    input  logic                 DReq,
    input  logic                 DWe,
    input  logic                 DByte,
    input  logic [WORD_SIZE-1:0] DAddr,
    input  logic [WORD_SIZE-1:0] DWData,
    output logic [WORD_SIZE-1:0] DRData,
    output logic                 DValid,
    output logic                 DBusy,
    output logic                 MemReq,
    output logic                 MemWe,
    output logic                 MemByte,
    output logic [WORD_SIZE-1:0] MemAddr,
    output logic [WORD_SIZE-1:0] MemWData,
    input  logic [WORD_SIZE-1:0] MemRData,
    input  logic                 MemAck,
    output logic                 BusErr
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    owner_e                 grant_q, grant_d;
    logic [3:0]             starve_q, starve_d;
    logic [7:0]             tmo_q, tmo_d;
    logic [WORD_SIZE-1:0]   irdata_q, irdata_d;
    logic [WORD_SIZE-1:0]   drdata_q, drdata_d;
    logic                   ivalid_q, ivalid_d;
    logic                   dvalid_q, dvalid_d;
    logic                   mem_we_q, mem_we_d;
    logic                   mem_byte_q, mem_byte_d;
    logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   bus_err_q, bus_err_d;
    logic                   d_wins;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        grant_d     = grant_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        ivalid_d    = 1'b0;
        dvalid_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_byte_d  = mem_byte_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        bus_err_d   = bus_err_q;
        d_wins      = DReq && !(IReq && (starve_q == STARVE_MAX));

        case (state_q)
            ST_IDLE: begin
                if (DReq || IReq) begin
                    state_d = ST_BUSY;
                    tmo_d   = '0;
                    if (d_wins) begin
                        grant_d     = OWN_D;
                        mem_we_d    = DWe;
                        mem_byte_d  = DByte;
                        mem_addr_d  = DAddr;
                        mem_wdata_d = DWData;
                        if (!IReq) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        grant_d     = OWN_I;
                        mem_we_d    = 1'b0;
                        mem_byte_d  = 1'b0;
                        mem_addr_d  = IAddr;
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end
                end else begin
                    starve_d = '0;
                end
            end

            ST_BUSY: begin
                if (MemAck) begin
                    state_d = ST_IDLE;
                    if (grant_q == OWN_D) begin
                        if (!mem_we_q) drdata_d = MemRData;
                        dvalid_d = 1'b1;
                    end else begin
                        irdata_d = MemRData;
                        ivalid_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abort: complete the owner with zero data and flag the bus error.
                    state_d   = ST_IDLE;
                    bus_err_d = 1'b1;
                    if (grant_q == OWN_D) begin
                        drdata_d = '0;
                        dvalid_d = 1'b1;
                    end else begin
                        irdata_d = '0;
                        ivalid_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= OWN_I;
            starve_q    <= '0;
            tmo_q       <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            ivalid_q    <= 1'b0;
            dvalid_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            grant_q     <= grant_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
            ivalid_q    <= ivalid_d;
            dvalid_q    <= dvalid_d;
            mem_we_q    <= mem_we_d;
            mem_byte_q  <= mem_byte_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign MemReq   = (state_q == ST_BUSY);
    assign MemWe    = mem_we_q;
    assign MemByte  = mem_byte_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign IRData   = irdata_q;
    assign DRData   = drdata_q;
    assign IValid   = ivalid_q;
    assign DValid   = dvalid_q;
    assign IBusy    = IReq & ~ivalid_q;
    assign DBusy    = DReq & ~dvalid_q;
    assign BusErr   = bus_err_q;

endmodule
